// File: rtl/fpga_sys_ctrl_if.sv
// fpga_sys_ctrl_if: control and status bundle between the system-control block and the FPGA top level.
interface fpga_sys_ctrl_if #(
    parameter int NumRstOut     = 3,
    parameter int BootModeWidth = 2
);
    logic                     pll_locked_i;
    logic                     sw_rst_i;
    logic                     test_mode_i;
    logic [BootModeWidth-1:0] boot_mode_i;
    logic [NumRstOut-1:0]     rst_no;
    logic [BootModeWidth-1:0] boot_mode_o;
    logic                     ready_o;
    logic                     rtc_o;
    logic                     rtc_tick_o;

    modport master (
        output pll_locked_i, sw_rst_i, test_mode_i, boot_mode_i,
        input  rst_no, boot_mode_o, ready_o, rtc_o, rtc_tick_o
    );
    modport slave (
        input  pll_locked_i, sw_rst_i, test_mode_i, boot_mode_i,
        output rst_no, boot_mode_o, ready_o, rtc_o, rtc_tick_o
    );
endinterface

// File: rtl/fpga_sys_ctrl.sv
// fpga_sys_ctrl: lock-gated staged reset sequencer, boot-mode latch and fractional RTC clock generator.
module fpga_sys_ctrl #(
    parameter int SocFreqHz      = 50000000,
    parameter int RtcFreqHz      = 1000000,
    parameter int NumRstOut      = 3,
    parameter int RstDelayCycles = 16,
    parameter int BootModeWidth  = 2
) (
    input  logic           soc_clk,
    input  logic           rst_n,
    fpga_sys_ctrl_if.slave sys
);
    localparam int AccW = $clog2(SocFreqHz + 2 * RtcFreqHz) + 1;
    localparam int StW  = NumRstOut > 1 ? $clog2(NumRstOut) : 1;
    localparam int CntW = $clog2(RstDelayCycles + 1);
    localparam logic [AccW-1:0] AccInc    = AccW'(2 * RtcFreqHz);
    localparam logic [AccW-1:0] AccMod    = AccW'(SocFreqHz);
    localparam logic [StW-1:0]  LastStage = StW'(NumRstOut - 1);
    localparam logic [CntW-1:0] LastCnt   = CntW'(RstDelayCycles - 1);

    if (2 * RtcFreqHz > SocFreqHz) begin : g_bad_rtc
        $error("fpga_sys_ctrl: RtcFreqHz must not exceed SocFreqHz/2");
    end
    if (NumRstOut < 1 || NumRstOut > 8 || RstDelayCycles < 1) begin : g_bad_rst
        $error("fpga_sys_ctrl: NumRstOut must be 1..8 and RstDelayCycles >= 1");
    end

    typedef enum logic [1:0] {WAIT_LOCK, SEQ, RUN} state_e;

    state_e                   state_q, state_d;
    logic [StW-1:0]           stage_q, stage_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [NumRstOut-1:0]     rel_q, rel_d;
    logic [BootModeWidth-1:0] boot_q;
    logic [AccW-1:0]          acc_q, acc_nxt;
    logic                     lock_meta_q, lock_s_q;
    logic                     rtc_q, tick_q, abort, wrap, rtc_en;

    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            {lock_s_q, lock_meta_q} <= '0;
        end else begin
            {lock_s_q, lock_meta_q} <= {lock_meta_q, sys.pll_locked_i};
        end
    end

    assign abort = sys.sw_rst_i || !lock_s_q;

    // The cycle in which lock is first seen already counts as the first delay cycle of stage 0.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        if (abort) begin
            state_d = WAIT_LOCK;
            stage_d = '0;
            cnt_d   = '0;
            rel_d   = '0;
        end else if (state_q != RUN) begin
            state_d = SEQ;
            if (cnt_q == LastCnt) begin
                cnt_d          = '0;
                rel_d[stage_q] = 1'b1;
                state_d        = stage_q == LastStage ? RUN : SEQ;
                stage_d        = stage_q == LastStage ? stage_q : stage_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            stage_q <= '0;
            cnt_q   <= '0;
            rel_q   <= '0;
            boot_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            if (rel_d[0] && !rel_q[0]) boot_q <= sys.boot_mode_i;
        end
    end

    // The RTC runs only while reset 0 is released and stays released; an abort clears it in the same edge.
    assign rtc_en  = rel_q[0] && rel_d[0];
    assign acc_nxt = acc_q + AccInc;
    assign wrap    = acc_nxt >= AccMod;

    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            rtc_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (!rtc_en) begin
            acc_q  <= '0;
            rtc_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= wrap ? acc_nxt - AccMod : acc_nxt;
            rtc_q  <= rtc_q ^ wrap;
            tick_q <= wrap && !rtc_q;
        end
    end

    assign sys.rst_no      = sys.test_mode_i ? {NumRstOut{rst_n}} : rel_q;
    assign sys.boot_mode_o = boot_q;
    assign sys.ready_o     = state_q == RUN;
    assign sys.rtc_o       = rtc_q;
    assign sys.rtc_tick_o  = tick_q;
endmodule

// File: tb/tb_fpga_sys_ctrl.sv
// tb_fpga_sys_ctrl: directed sequences, a test-mode vector table and random stimulus against a
// behavioural model that tracks consecutive qualifying cycles and a closed-form RTC toggle count.
module tb_fpga_sys_ctrl;
    localparam int N  = 3;
    localparam int D  = 16;
    localparam int BW = 2;
    localparam longint S = 50000000;
    localparam longint R = 1000000;

    logic soc_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic rst2_n  = 1'b0;
    always #5 soc_clk = ~soc_clk;

    fpga_sys_ctrl_if #(.NumRstOut(N), .BootModeWidth(BW)) bus ();
    fpga_sys_ctrl_if #(.NumRstOut(2), .BootModeWidth(1)) bus2 ();

    fpga_sys_ctrl #(.SocFreqHz(50000000), .RtcFreqHz(1000000), .NumRstOut(N),
                    .RstDelayCycles(D), .BootModeWidth(BW)) dut (
        .soc_clk(soc_clk), .rst_n(rst_n), .sys(bus.slave));

    fpga_sys_ctrl #(.SocFreqHz(10), .RtcFreqHz(3), .NumRstOut(2),
                    .RstDelayCycles(2), .BootModeWidth(1)) dut2 (
        .soc_clk(soc_clk), .rst_n(rst2_n), .sys(bus2.slave));

    int checks = 0;
    int errors = 0;

    // Model state: g = consecutive cycles with lock seen and no software reset.
    int            g;
    logic          s1m, s2m;
    logic [BW-1:0] bootm;
    longint        n;

    typedef struct {
        logic         tm;
        logic         rn;
        logic [N-1:0] exp;
    } tv_t;
    tv_t tv[6];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint tog(input longint k);
        return k * 2 * R / S;
    endfunction

    task automatic check_all();
        logic [N-1:0] er;
        logic         er_rtc, er_tick;
        for (int k = 0; k < N; k++) er[k] = bus.test_mode_i ? rst_n : (g >= (k + 1) * D);
        er_rtc  = tog(n) % 2 == 1;
        er_tick = n > 0 && tog(n) != tog(n - 1) && er_rtc;
        chk("rst_no", bus.rst_no, er);
        chk("ready_o", bus.ready_o, g >= N * D);
        chk("boot_mode_o", bus.boot_mode_o, bootm);
        chk("rtc_o", bus.rtc_o, er_rtc);
        chk("rtc_tick_o", bus.rtc_tick_o, er_tick);
    endtask

    task automatic step();
        int   gp;
        logic good;
        @(posedge soc_clk);
        if (!rst_n) begin
            g = 0; s1m = 0; s2m = 0; bootm = '0; n = 0;
        end else begin
            good = s2m && !bus.sw_rst_i;
            gp   = g;
            g    = good ? (g < N * D ? g + 1 : g) : 0;
            s2m  = s1m;
            s1m  = bus.pll_locked_i;
            if (gp < D && g >= D) bootm = bus.boot_mode_i;
            n = (gp >= D && g >= D) ? n + 1 : 0;
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [N-1:0] prev;
        int first[N];
        int rdy_first, ntr, cnt, hi, lo, tk, gap, max_gap, tk_bad;
        bit seen;
        logic smp[21];
        logic tks[21];

        tv[0] = '{1'b1, 1'b1, 3'b111};
        tv[1] = '{1'b1, 1'b0, 3'b000};
        tv[2] = '{1'b1, 1'b1, 3'b111};
        tv[3] = '{1'b0, 1'b1, 3'b000};
        tv[4] = '{1'b0, 1'b0, 3'b000};
        tv[5] = '{1'b1, 1'b0, 3'b000};

        bus.pll_locked_i = 1; bus.sw_rst_i = 0; bus.test_mode_i = 0; bus.boot_mode_i = 2'b01;
        bus2.pll_locked_i = 1; bus2.sw_rst_i = 0; bus2.test_mode_i = 0; bus2.boot_mode_i = 1'b1;
        g = 0; s1m = 0; s2m = 0; bootm = '0; n = 0;
        for (int i = 0; i < 3; i++) step();

        // Power-up sequence from reset release.
        @(negedge soc_clk);
        rst_n = 1; rst2_n = 1;
        for (int k = 0; k < N; k++) first[k] = -1;
        rdy_first = -1; ntr = 0;
        for (int e = 1; e <= 60; e++) begin
            prev = bus.rst_no;
            step();
            for (int k = 0; k < N; k++) if (bus.rst_no[k] && !prev[k] && first[k] < 0) first[k] = e;
            ntr += $countones(bus.rst_no ^ prev);
            if (bus.ready_o && rdy_first < 0) rdy_first = e;
        end
        chk("rise_edge_0", first[0], 18);
        chk("rise_edge_1", first[1], 34);
        chk("rise_edge_2", first[2], 50);
        chk("ready_edge", rdy_first, 50);
        chk("rst_transitions", ntr, 3);
        chk("boot_latch", bus.boot_mode_o, 2'b01);

        // RTC period 50 cycles, 25 high / 25 low, a single tick at each rise.
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin step(); seen = bus.rtc_tick_o; end
        chk("rtc_tick_seen", seen, 1);
        hi = 1; lo = 0; tk = 0;
        for (int i = 0; i < 49; i++) begin
            step();
            if (bus.rtc_o) hi++; else lo++;
            tk += bus.rtc_tick_o;
        end
        step();
        chk("rtc_high_cycles", hi, 25);
        chk("rtc_low_cycles", lo, 25);
        chk("rtc_ticks_between", tk, 0);
        chk("rtc_next_tick", bus.rtc_tick_o, 1);

        // Software reset pulse in RUN, restart and boot-mode re-latch.
        bus.boot_mode_i = 2'b10; bus.sw_rst_i = 1;
        step();
        bus.sw_rst_i = 0;
        chk("abort_rst_no", bus.rst_no, 0);
        chk("abort_ready", bus.ready_o, 0);
        chk("abort_rtc", bus.rtc_o, 0);
        for (int k = 0; k < N; k++) first[k] = -1;
        for (int e = 1; e <= 60; e++) begin
            prev = bus.rst_no;
            step();
            for (int k = 0; k < N; k++) if (bus.rst_no[k] && !prev[k] && first[k] < 0) first[k] = e;
        end
        chk("restart_rise_0", first[0], 16);
        chk("restart_rise_1", first[1], 32);
        chk("restart_rise_2", first[2], 48);
        chk("boot_relatch", bus.boot_mode_o, 2'b10);
        bus.boot_mode_i = 2'b01;
        for (int i = 0; i < 5; i++) step();
        chk("boot_hold_run", bus.boot_mode_o, 2'b10);

        // Lock lost mid-sequence, just after reset 0 is released.
        bus.sw_rst_i = 1; step(); bus.sw_rst_i = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin step(); seen = bus.rst_no[0]; end
        chk("seq_r0_seen", seen, 1);
        bus.pll_locked_i = 0;
        step(); chk("lockdrop_hold_1", bus.rst_no, 3'b001);
        step(); chk("lockdrop_hold_2", bus.rst_no, 3'b001);
        step(); chk("lockdrop_clear", bus.rst_no, 3'b000);

        // Lock held low for 100 cycles, then raised.
        cnt = 0;
        for (int i = 0; i < 100; i++) begin step(); cnt += $countones(bus.rst_no); end
        chk("nolock_rst_high", cnt, 0);
        bus.pll_locked_i = 1;
        cnt = -1;
        for (int i = 1; i <= 40 && cnt < 0; i++) begin step(); if (bus.rst_no[0]) cnt = i; end
        chk("lock_to_r0", cnt, 18);

        // Fractional RTC at SocFreqHz=10, RtcFreqHz=3.
        smp[0] = bus2.rtc_o; tks[0] = 0;
        for (int i = 1; i <= 20; i++) begin step(); smp[i] = bus2.rtc_o; tks[i] = bus2.rtc_tick_o; end
        cnt = 0; tk = 0; gap = 0; max_gap = 0; tk_bad = 0;
        for (int i = 1; i <= 20; i++) begin
            gap++;
            if (smp[i] != smp[i-1]) begin
                cnt++;
                if (cnt > 1 && gap > max_gap) max_gap = gap;
                gap = 0;
            end
            tk += tks[i];
            if (tks[i] != (smp[i] && !smp[i-1])) tk_bad++;
        end
        chk("frac_toggles", cnt, 12);
        chk("frac_ticks", tk, 6);
        chk("frac_max_half", max_gap, 2);
        chk("frac_tick_align", tk_bad, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (bus.pll_locked_i) bus.pll_locked_i = $urandom_range(0, 299) != 0;
            else                  bus.pll_locked_i = $urandom_range(0, 4) == 0;
            bus.sw_rst_i    = $urandom_range(0, 199) == 0;
            bus.test_mode_i = $urandom_range(0, 499) == 0;
            bus.boot_mode_i = BW'($urandom);
            step();
        end

        // Test-mode bypass follows rst_n combinationally.
        bus.pll_locked_i = 1; bus.sw_rst_i = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge soc_clk);
            bus.test_mode_i = tv[i].tm;
            rst_n = tv[i].rn;
            #1;
            chk($sformatf("test_mode_vec%0d", i), bus.rst_no, tv[i].exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
